// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encodings,
// opcodes, ALUOp codes, datapath select codes and the decoded control word.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // DECODE dispatch target; S_FETCH marks an unsupported opcode.
    function automatic state_e decode_dispatch(input logic [6:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:         nxt = S_EXECUTER;
            OP_I:         nxt = S_EXECUTEI;
            OP_BEQ:       nxt = S_BEQ;
            OP_JAL:       nxt = S_JAL;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Pure combinational state -> control word decoder for main_fsm.
// Handshake gating and reset forcing are applied by the parent.
module main_fsm_outdec
    import riscv_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o            = '0;
        ctrl_o.adr_src    = ADR_PC;
        ctrl_o.result_src = RES_ALURESULT;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_update = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_MEMREAD: begin
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.adr_src    = ADR_RESULT;
            end
            S_MEMWB: begin
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.adr_src    = ADR_RESULT;
                ctrl_o.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_FUNCT;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_EXECUTEI: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.alu_op     = ALUOP_FUNCT;
                ctrl_o.result_src = RES_ALUOUT;
            end
            S_ALUWB: begin
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_update  = 1'b1;
            end
            // Unused encodings keep FETCH muxes with every enable low.
            default: ;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I main controller: state register, next-state logic,
// memory-ready gating and reset forcing around main_fsm_outdec.
//
// state      | meaning
// FETCH      | read instruction at PC, PC += 4 when memory ready
// DECODE     | read registers, compute branch/jump target, dispatch on op
// MEMADR     | compute load/store address rs1 + imm
// MEMREAD    | load access, wait for memory ready
// MEMWB      | write loaded data to register file
// MEMWRITE   | store access, wait for memory ready
// EXECUTER   | register-register ALU operation
// EXECUTEI   | register-immediate ALU operation
// ALUWB      | write ALU result to register file
// BEQ        | compare rs1/rs2, take branch on Zero
// JAL        | PC <- target, compute link address
module main_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   illegal_d;
    logic   fetch_gate;

    main_fsm_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d   = decode_dispatch(op);
                illegal_d = (state_d == S_FETCH);
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        if (reset) state_d = S_FETCH;
    end

    // Only the FETCH updates wait on memory; JAL's PC update is unconditional.
    assign fetch_gate = (state_q != S_FETCH) | mem_ready;

    always_comb begin
        AdrSrc     = ctrl.adr_src;
        ResultSrc  = ctrl.result_src;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ALUOp      = ctrl.alu_op;
        IRWrite    = ctrl.ir_write & fetch_gate & ~reset;
        PCWrite    = ((ctrl.pc_update & fetch_gate) | (ctrl.branch & Zero)) & ~reset;
        MemWrite   = ctrl.mem_write & ~reset;
        RegWrite   = ctrl.reg_write & ~reset;
        illegal_op = illegal_d & ~reset;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_main_fsm.sv
// Randomized self-checking bench for main_fsm: a per-instruction state-path
// model plus a per-state control table drive every comparison.
module tb_main_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset, Zero, mem_ready;
    logic [6:0] op;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int path[$];

    main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op}
    function automatic logic [13:0] exp_ctrl(input int st, input logic [6:0] o,
                                             input logic mr, input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, a, b, aop;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {res, a, b, aop} = '0;
        case (st)
            0:  begin b = 2; res = 2; irw = mr; pcw = mr; end
            1:  begin a = 1; b = 1; ill = !legal(o); end
            2:  begin a = 2; b = 1; end
            3:  adr = 1;
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2; aop = 2; end
            7:  begin a = 2; b = 1; aop = 2; end
            8:  rw = 1;
            9:  begin a = 2; aop = 1; pcw = z; end
            10: begin a = 1; b = 2; pcw = 1; end
            default: ;
        endcase
        if (rst) {pcw, irw, mw, rw, ill} = '0;
        return {pcw, adr, mw, irw, rw, res, a, b, aop, ill};
    endfunction

    // Expected state path for one instruction, ignoring memory stalls.
    task automatic build_path(input logic [6:0] o);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        case (o)
            LW: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            SW: begin path.push_back(2); path.push_back(5); end
            RT: begin path.push_back(6); path.push_back(8); end
            IT: begin path.push_back(7); path.push_back(8); end
            BQ: path.push_back(9);
            JL: begin path.push_back(10); path.push_back(8); end
            default: ;
        endcase
    endtask

    task automatic cycle_chk(input int st, input logic [6:0] o, input logic mr,
                             input logic z, input logic rst);
        @(posedge clk);
        #1;
        op = o; mem_ready = mr; Zero = z; reset = rst;
        #3;
        check($sformatf("state(op=%b)", o), {28'd0, state_dbg}, st);
        check($sformatf("ctrl(st=%0d op=%b mr=%b z=%b rst=%b)", st, o, mr, z, rst),
              {18'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op},
              {18'd0, exp_ctrl(st, o, mr, z, rst)});
    endtask

    // mr_pat bit k is mem_ready in the k-th cycle of the instruction (1 beyond bit 31).
    task automatic run_instr(input logic [6:0] o, input logic z, input logic [31:0] mr_pat);
        int idx = 0;
        int cyc = 0;
        logic mr;
        logic [6:0] od;
        build_path(o);
        while (idx < path.size()) begin
            mr = (cyc < 32) ? mr_pat[cyc] : 1'b1;
            od = (path[idx] == 0) ? 7'($urandom) : o;
            cycle_chk(path[idx], od, mr, z, 1'b0);
            if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mr)) idx++;
            cyc++;
            if (cyc > 100) begin
                check("cycle_budget", 32'(cyc), 32'd100);
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; op = RT; Zero = 1'b0;
        @(posedge clk);
        cycle_chk(0, RT, 1'b1, 1'b0, 1'b1);

        run_instr(RT, 1'b0, 32'hFFFF_FFFF);
        run_instr(LW, 1'b0, 32'hFFFF_FFE7);
        run_instr(SW, 1'b0, 32'hFFFF_FFFE);
        run_instr(BQ, 1'b1, 32'hFFFF_FFFF);
        run_instr(BQ, 1'b0, 32'hFFFF_FFFF);
        run_instr(JL, 1'b0, 32'hFFFF_FFFF);
        run_instr(IT, 1'b1, 32'hFFFF_FFFF);
        run_instr(7'b1111111, 1'b0, 32'hFFFF_FFFF);

        // Reset while a store is waiting on memory.
        cycle_chk(0, SW, 1'b1, 1'b0, 1'b0);
        cycle_chk(1, SW, 1'b1, 1'b0, 1'b0);
        cycle_chk(2, SW, 1'b0, 1'b0, 1'b0);
        cycle_chk(5, SW, 1'b0, 1'b0, 1'b0);
        cycle_chk(5, SW, 1'b0, 1'b0, 1'b1);
        cycle_chk(0, SW, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            case ($urandom_range(0, 6))
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BQ;
                5: o = JL;
                default: o = 7'($urandom);
            endcase
            run_instr(o, 1'($urandom), $urandom | $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
